// File: rtl/func_unit_seq.sv
// func_unit_seq: sequential ALU/shifter with registered result and flags.
// ALU ops finish in one cycle; shifts and rotates step one bit per clock
// through a work register, so no barrel shifter is built.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; ALU ops and zero-length shifts finish here
// SHIFT  | stepping the work register one bit per clock until cnt hits 0

module func_unit_seq #(
  parameter  int WIDTH = 16,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] F,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam logic [1:0] SH_SHL = 2'b00;
  localparam logic [1:0] SH_SHR = 2'b01;
  localparam logic [1:0] SH_SAR = 2'b10;
  localparam logic [1:0] SH_ROL = 2'b11;

  state_t           r_state;
  logic [SW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_work;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_f;
  logic             r_z;
  logic             r_n;
  logic             r_c;
  logic             r_v;
  logic             r_done;

  state_t           w_state_nxt;
  logic [SW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_work_nxt;
  logic [1:0]       w_op_nxt;
  logic             w_load;
  logic [WIDTH-1:0] w_f_nxt;
  logic             w_c_nxt;
  logic             w_v_nxt;
  logic             w_busy;

  logic [SW-1:0]    w_amt;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH-1:0] w_alu_f;
  logic             w_alu_c;
  logic             w_alu_v;
  logic [WIDTH-1:0] w_step;
  logic             w_step_out;

  assign w_amt = A[SW-1:0];
  assign w_add = {1'b0, A} + {1'b0, B};
  assign w_sub = {1'b0, A} - {1'b0, B};
  assign w_inc = {1'b0, A} + (WIDTH+1)'(1);

  // single-cycle ALU result, carry/borrow and signed overflow
  always_comb begin
    w_alu_f = '0;
    w_alu_c = 1'b0;
    w_alu_v = 1'b0;
    case (sel[2:0])
      3'b000: begin
        w_alu_f = w_add[WIDTH-1:0];
        w_alu_c = w_add[WIDTH];
        w_alu_v = (A[WIDTH-1] == B[WIDTH-1]) && (w_add[WIDTH-1] != A[WIDTH-1]);
      end
      3'b001: begin
        // the extra top bit of the zero-extended difference is the borrow (A<B)
        w_alu_f = w_sub[WIDTH-1:0];
        w_alu_c = w_sub[WIDTH];
        w_alu_v = (A[WIDTH-1] != B[WIDTH-1]) && (w_sub[WIDTH-1] != A[WIDTH-1]);
      end
      3'b010: w_alu_f = A & B;
      3'b011: w_alu_f = A | B;
      3'b100: w_alu_f = A ^ B;
      3'b101: w_alu_f = ~A;
      3'b110: w_alu_f = B;
      default: begin
        w_alu_f = w_inc[WIDTH-1:0];
        w_alu_c = w_inc[WIDTH];
        w_alu_v = !A[WIDTH-1] && w_inc[WIDTH-1];
      end
    endcase
  end

  // one-bit step of the work register and the bit that leaves it
  always_comb begin
    w_step     = r_work;
    w_step_out = 1'b0;
    case (r_op)
      SH_SHL: begin
        w_step     = {r_work[WIDTH-2:0], 1'b0};
        w_step_out = r_work[WIDTH-1];
      end
      SH_SHR: begin
        w_step     = {1'b0, r_work[WIDTH-1:1]};
        w_step_out = r_work[0];
      end
      SH_SAR: begin
        w_step     = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
        w_step_out = r_work[0];
      end
      default: begin
        // for ROL the bit leaving the top is also the bit entering bit 0
        w_step     = {r_work[WIDTH-2:0], r_work[WIDTH-1]};
        w_step_out = r_work[WIDTH-1];
      end
    endcase
  end

  // next-state, work register and result-load decisions
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_work_nxt  = r_work;
    w_op_nxt    = r_op;
    w_load      = 1'b0;
    w_f_nxt     = r_f;
    w_c_nxt     = r_c;
    w_v_nxt     = r_v;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (!sel[3]) begin
            w_load  = 1'b1;
            w_f_nxt = w_alu_f;
            w_c_nxt = w_alu_c;
            w_v_nxt = w_alu_v;
          end else if (w_amt == '0) begin
            w_load  = 1'b1;
            w_f_nxt = B;
            w_c_nxt = 1'b0;
            w_v_nxt = 1'b0;
          end else begin
            w_state_nxt = S_SHIFT;
            w_cnt_nxt   = w_amt;
            w_work_nxt  = B;
            w_op_nxt    = sel[1:0];
          end
        end
      end
      S_SHIFT: begin
        w_busy     = 1'b1;
        w_cnt_nxt  = r_cnt - SW'(1);
        w_work_nxt = w_step;
        if (r_cnt == SW'(1)) begin
          w_load      = 1'b1;
          w_f_nxt     = w_step;
          w_c_nxt     = w_step_out;
          w_v_nxt     = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // state, counter and work register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_work  <= '0;
      r_op    <= SH_SHL;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_work  <= w_work_nxt;
      r_op    <= w_op_nxt;
    end
  end

  // result and flags move only on a completing edge; done marks that edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_f    <= '0;
      r_z    <= 1'b0;
      r_n    <= 1'b0;
      r_c    <= 1'b0;
      r_v    <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_load;
      if (w_load) begin
        r_f <= w_f_nxt;
        r_z <= (w_f_nxt == '0);
        r_n <= w_f_nxt[WIDTH-1];
        r_c <= w_c_nxt;
        r_v <= w_v_nxt;
      end
    end
  end

  assign F    = r_f;
  assign Z    = r_z;
  assign N    = r_n;
  assign C    = r_c;
  assign V    = r_v;
  assign busy = w_busy;
  assign done = r_done;

endmodule

// File: tb/tb_func_unit_seq.sv
// Directed bench for func_unit_seq: a vector table of ALU and shift ops
// on a 16-bit instance, hand sequences for back-to-back issue, start while
// busy and reset mid-shift, and an 8-bit instance for the long-shift corner.

module tb_func_unit_seq;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [3:0]  sel;
  logic [15:0] A, B, F;
  logic        Z, N, C, V, busy, done;

  logic        rst8, start8;
  logic [3:0]  sel8;
  logic [7:0]  A8, B8, F8;
  logic        Z8, N8, C8, V8, busy8, done8;

  int total = 0;
  int bad   = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  func_unit_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .A(A), .B(B),
    .F(F), .Z(Z), .N(N), .C(C), .V(V), .busy(busy), .done(done)
  );

  func_unit_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .sel(sel8), .A(A8), .B(B8),
    .F(F8), .Z(Z8), .N(N8), .C(C8), .V(V8), .busy(busy8), .done(done8)
  );

  always @(negedge clk) begin
    if ((busy && done) || (busy8 && done8)) overlap++;
  end

  typedef struct {
    logic [3:0]  sel;
    logic [15:0] a;
    logic [15:0] b;
    int          lat;
    logic [15:0] f;
    logic [3:0]  flg;   // {Z,N,C,V}
    string       nm;
  } vec_t;

  vec_t vt [0:22];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b,
                        input int exp_lat, input logic [15:0] ef, input logic [3:0] eflg,
                        input string nm);
    int lat;
    int bcnt;
    @(negedge clk);
    start = 1'b1; sel = s; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; sel = 4'h0; A = 16'hDEAD; B = 16'hBEEF;
    lat = 1; bcnt = 0;
    while (!done && lat < 80) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_busycycles"}, bcnt, exp_lat - 1);
    chk({nm, "_F"}, F, ef);
    chk({nm, "_ZNCV"}, {Z, N, C, V}, eflg);
  endtask

  task automatic run8(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b,
                      input int exp_lat, input logic [7:0] ef, input logic [3:0] eflg,
                      input string nm);
    int lat;
    @(negedge clk);
    start8 = 1'b1; sel8 = s; A8 = a; B8 = b;
    @(posedge clk); #1;
    start8 = 1'b0; A8 = 8'h55; B8 = 8'hAA;
    lat = 1;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_F"}, F8, ef);
    chk({nm, "_ZNCV"}, {Z8, N8, C8, V8}, eflg);
  endtask

  initial begin
    int dones;
    int dlat;

    vt[0]  = '{4'b0000, 16'h7FFF, 16'h0001, 1,  16'h8000, 4'b0101, "add_ovf"};
    vt[1]  = '{4'b0000, 16'hFFFF, 16'h0001, 1,  16'h0000, 4'b1010, "add_carry"};
    vt[2]  = '{4'b0001, 16'h0003, 16'h0003, 1,  16'h0000, 4'b1000, "sub_zero"};
    vt[3]  = '{4'b0001, 16'h0001, 16'h0002, 1,  16'hFFFF, 4'b0110, "sub_borrow"};
    vt[4]  = '{4'b0001, 16'h8000, 16'h0001, 1,  16'h7FFF, 4'b0001, "sub_ovf"};
    vt[5]  = '{4'b0010, 16'h00F0, 16'h0FF0, 1,  16'h00F0, 4'b0000, "and"};
    vt[6]  = '{4'b0011, 16'h00F0, 16'h0F0F, 1,  16'h0FFF, 4'b0000, "or"};
    vt[7]  = '{4'b0100, 16'hF0F0, 16'hFFFF, 1,  16'h0F0F, 4'b0000, "xor"};
    vt[8]  = '{4'b0101, 16'h0000, 16'h1234, 1,  16'hFFFF, 4'b0100, "not"};
    vt[9]  = '{4'b0110, 16'hFFFF, 16'h8000, 1,  16'h8000, 4'b0100, "pass"};
    vt[10] = '{4'b0111, 16'h7FFF, 16'h0000, 1,  16'h8000, 4'b0101, "inc_ovf"};
    vt[11] = '{4'b0111, 16'hFFFF, 16'h0000, 1,  16'h0000, 4'b1010, "inc_carry"};
    vt[12] = '{4'b0010, 16'hF0F0, 16'h0F0F, 1,  16'h0000, 4'b1000, "and_zero"};
    vt[13] = '{4'b1010, 16'h0004, 16'h8001, 5,  16'hF800, 4'b0100, "sar4"};
    vt[14] = '{4'b1011, 16'h0001, 16'h8000, 2,  16'h0001, 4'b0010, "rol1"};
    vt[15] = '{4'b1000, 16'h0000, 16'h1234, 1,  16'h1234, 4'b0000, "shl0"};
    vt[16] = '{4'b1100, 16'h0001, 16'h8001, 2,  16'h0002, 4'b0010, "shl1_sel2"};
    vt[17] = '{4'b1001, 16'h0001, 16'h0003, 2,  16'h0001, 4'b0010, "shr1"};
    vt[18] = '{4'b1001, 16'h000F, 16'hFFFF, 16, 16'h0001, 4'b0010, "shr15"};
    vt[19] = '{4'b1000, 16'hFFF3, 16'h0001, 4,  16'h0008, 4'b0000, "shl3_amtmask"};
    vt[20] = '{4'b1011, 16'h0004, 16'h1234, 5,  16'h2341, 4'b0010, "rol4"};
    vt[21] = '{4'b1010, 16'h000F, 16'h4000, 16, 16'h0000, 4'b1010, "sar15"};
    vt[22] = '{4'b1010, 16'h0003, 16'h8000, 4,  16'hF000, 4'b0100, "sar3"};

    rst = 1'b1; start = 1'b0; sel = 4'h0; A = '0; B = '0;
    rst8 = 1'b1; start8 = 1'b0; sel8 = 4'h0; A8 = '0; B8 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_F", F, 16'h0000);
    chk("reset_ZNCV", {Z, N, C, V}, 4'b0000);
    chk("reset_busy_done", {busy, done}, 2'b00);
    chk("reset8_F", F8, 8'h00);
    @(negedge clk);
    rst = 1'b0; rst8 = 1'b0;

    for (int i = 0; i <= 22; i++)
      run_op(vt[i].sel, vt[i].a, vt[i].b, vt[i].lat, vt[i].f, vt[i].flg, vt[i].nm);

    // back to back: second SUB issued in the done cycle of the first
    @(negedge clk);
    start = 1'b1; sel = 4'b0001; A = 16'h0003; B = 16'h0003;
    @(posedge clk); #1;
    chk("b2b_done1", done, 1'b1);
    chk("b2b_F1", {F, Z, C}, {16'h0000, 1'b1, 1'b0});
    sel = 4'b0001; A = 16'h0001; B = 16'h0002;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_done2", done, 1'b1);
    chk("b2b_F2", {F, C, N}, {16'hFFFF, 1'b1, 1'b1});
    @(posedge clk); #1;
    chk("b2b_done_drop", done, 1'b0);

    // start pulse with different operands while a SAR is busy is ignored
    @(negedge clk);
    start = 1'b1; sel = 4'b1010; A = 16'h0004; B = 16'h8001;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0; dlat = 0;
    for (int k = 1; k <= 10; k++) begin
      if (done) begin dones++; dlat = k; end
      if (k == 2) begin start = 1'b1; sel = 4'b0000; A = 16'h0001; B = 16'h0001; end
      if (k == 3) start = 1'b0;
      @(posedge clk); #1;
    end
    chk("busy_ign_dones", dones, 1);
    chk("busy_ign_lat", dlat, 5);
    chk("busy_ign_F", {F, Z, N, C, V}, {16'hF800, 4'b0100});

    // reset in the 3rd busy cycle of a long SHR aborts it silently
    run_op(4'b0111, 16'h7FFF, 16'h0000, 1, 16'h8000, 4'b0101, "pre_rst_inc");
    @(negedge clk);
    start = 1'b1; sel = 4'b1001; A = 16'h000F; B = 16'hFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_F", F, 16'h0000);
    chk("abort_flags_busy_done", {Z, N, C, V, busy, done}, 6'b000000);
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", dones, 0);
    run_op(4'b0010, 16'h00F0, 16'h0FF0, 1, 16'h00F0, 4'b0000, "post_rst_and");

    // 8-bit instance
    run8(4'b1000, 8'h07, 8'h81, 8, 8'h80, 4'b0100, "w8_shl7");
    run8(4'b0000, 8'h80, 8'h80, 1, 8'h00, 4'b1011, "w8_add");
    run8(4'b1011, 8'h03, 8'hA5, 4, 8'h2D, 4'b0010, "w8_rol3");

    chk("busy_done_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/func_unit_seq.md
# func_unit_seq

Parametrised sequential function unit, the successor to the combinational 16-bit ALU/shifter unit in the datapath. It performs single-cycle arithmetic/logic operations and multi-bit shifts/rotates. Shifts are iterated one bit per clock, so no barrel shifter is needed. Results and a full flag set (Z, N, C, V) are registered and announced with a start/busy/done handshake, so the control unit can issue operations back to back.

## Interface
- WIDTH, 16, operand/result width in bits; legal range 4..64.
- SW, $clog2(WIDTH), shift-amount width; derived, not overridden.

- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- sel  input  4  operation select; sampled with start.
- A  input  WIDTH  operand A; for shifts, A[SW-1:0] is the shift amount.
- B  input  WIDTH  operand B; for shifts, the value to be shifted.
- F  output  WIDTH  registered result; holds until the next done.
- Z  output  1  registered zero flag (F==0).
- N  output  1  registered negative flag (F[WIDTH-1]).
- C  output  1  registered carry/borrow/shifted-out bit.
- V  output  1  registered signed overflow.
- busy  output  1  high while a multi-cycle shift is in progress.
- done  output  1  one-cycle pulse in the cycle F/flags are first valid.

## Operation
- sel[3]=0 selects ALU ops, coded by sel[2:0]:
  - 000 ADD A+B: C = carry out; V = signed overflow.
  - 001 SUB A-B: C = borrow (A<B unsigned); V = signed overflow.
  - 010 AND, 011 OR, 100 XOR.
  - 101 NOT A.
  - 110 PASS B.
  - 111 INC A+1, with C and V as for ADD.
  - The logic ops (AND, OR, XOR, NOT, PASS) force C=0 and V=0.
- sel[3]=1 selects shift ops on B by n=A[SW-1:0], coded by sel[1:0]:
  - 00 SHL (logical left).
  - 01 SHR (logical right).
  - 10 SAR (arithmetic right, MSB replicated).
  - 11 ROL (rotate left).
  - sel[2] is ignored for shifts.
  - C = the last bit shifted out; for ROL, the last bit rotated into bit 0.
  - V=0.
  - n=0 gives F=B and C=0.
- Z and N are always computed from the final F.
- FSM has two states, IDLE and SHIFT.
  - IDLE, start=1, ALU op or shift with n=0: latch F and flags, pulse done, stay IDLE.
  - IDLE, start=1, shift with n>0: load work register W=B and counter cnt=n, go to SHIFT, busy=1.
  - SHIFT, each edge: W = one-bit shift of W, cnt=cnt-1, C candidate = the bit leaving W.
  - SHIFT, when cnt goes 1->0: on that edge F=shifted W, flags latch, done=1, busy=0, go to IDLE.
- start while busy=1 is ignored; no queueing.
- A, B and sel are captured at acceptance. Changes to them during SHIFT have no effect.
- F and the flags change only on an edge that sets done (or on reset).

## Timing
- Reset: F=0, Z=0, N=0, C=0, V=0, busy=0, done=0, state IDLE, cnt=0.
- Reset asserted mid-shift aborts the operation: no done pulse, and all outputs return to their reset values on that edge.
- ALU op (or shift with n=0) accepted at edge t: done=1 and F valid in the cycle after edge t, i.e. latency 1.
- Shift with n>0 accepted at edge t:
  - busy=1 in the cycles after edges t .. t+n-1.
  - done=1 and F valid in the cycle after edge t+n, i.e. latency n+1.
  - Maximum latency is WIDTH edges, at n=WIDTH-1.
- done is high for exactly one cycle. busy and done are never high together.
- Back to back: in the done cycle the state is IDLE, so a new start in that cycle is accepted at the next edge, giving one operation per cycle for ALU ops.
- The counter is SW bits wide; no wrap occurs because n is at most WIDTH-1.

## Test plan
- Reset, then ADD A=16'h7FFF, B=16'h0001 -> next cycle: F=16'h8000, N=1, V=1, C=0, Z=0, done for 1 cycle.
- SUB A=16'h0003, B=16'h0003, then SUB A=16'h0001, B=16'h0002 issued on the done cycle -> F=0, Z=1, C=0; then F=16'hFFFF, C=1, N=1, on consecutive cycles.
- SAR B=16'h8001, A=4 (n=4) -> busy for 4 cycles, done on the 5th cycle after the accepting edge; F=16'hF800, C=0, N=1. A start pulse during busy is ignored, with no extra done.
- ROL B=16'h8000, A=1 -> F=16'h0001, C=1, latency 2. SHL with n=0, B=16'h1234 -> F=16'h1234, C=0, latency 1.
- SHR B=16'hFFFF, n=15, with rst asserted in the 3rd busy cycle -> on that edge F=0, all flags 0, busy=0, and no done pulse. A following AND A=16'h00F0, B=16'h0FF0 -> F=16'h00F0.
- WIDTH=8 instance: SHL B=8'h81, n=7 -> F=8'h80, C=0 (the last bit shifted out is bit 1 of the original value), latency 8.
